hazard_ctrl_mc: RTL and testbench

- Parametrised hazard controller for the 5-stage RISC-V pipeline; successor to the single-cycle load-use/branch-flush detector.
- Adds a configurable multi-cycle load-use bubble, a whole-pipeline freeze on data-cache miss, and operand-use qualification so unused rs fields do not cause false stalls.
- Fixes priority: a load-use stall beats a branch flush.
- Adds saturating stall/flush/freeze performance counters.
- Sits beside the ID stage; drives PC enable, IF/ID stall/flush, ID/EX bubble select and global freeze.

---
 rtl/hazard_ctrl_mc.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hazard_ctrl_mc                                             |
// | Brief   : 5-stage pipeline hazard controller. Multi-cycle load-use   |
// |           bubble, whole-pipeline freeze on D-cache miss, operand-use |
// |           qualified hazard check, saturating performance counters.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hazard_ctrl_mc #(
  parameter int RA_W     = 5,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_IDEX_i,
  input  logic [RA_W-1:0]   rd_IDEX_i,
  input  logic [RA_W-1:0]   rs1_IFID_i,
  input  logic [RA_W-1:0]   rs2_IFID_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic              ID_equal_i,
  input  logic              isBranch_i,
  input  logic              mem_stall_i,
  input  logic              clr_cnt_i,
  output logic              PCWrite_o,
  output logic              IFIDStall_o,
  output logic              IFIDFlush_o,
  output logic              NoOp_o,
  output logic              Freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  freeze_cnt_o
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } state_t;

  // Extra bubble cycles loaded on entry to LU_WAIT (the entry cycle is the first).
  localparam logic [3:0]       LU_INIT = 4'(LU_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  logic lu_hit;
  logic br_tk;
  logic is_stall, is_flush, is_freeze;

  // Hazard terms: x0 never carries a dependency, unused source fields are ignored.
  assign lu_hit = MemRead_IDEX_i & (rd_IDEX_i != '0) &
                  ((rs1_used_i & (rd_IDEX_i == rs1_IFID_i)) |
                   (rs2_used_i & (rd_IDEX_i == rs2_IFID_i)));
  assign br_tk  = ID_equal_i & isBranch_i;

  // Prioritised output decode (freeze > stall > flush > run) and next state.
  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    PCWrite_o   = 1'b1;
    IFIDStall_o = 1'b0;
    IFIDFlush_o = 1'b0;
    NoOp_o      = 1'b0;
    Freeze_o    = 1'b0;
    is_stall    = 1'b0;
    is_flush    = 1'b0;
    is_freeze   = 1'b0;
    if (!rst_i) begin
      PCWrite_o = 1'b0;
    end else if (mem_stall_i) begin
      PCWrite_o   = 1'b0;
      IFIDStall_o = 1'b1;
      Freeze_o    = 1'b1;
      is_freeze   = 1'b1;
    end else if (state_q == LU_WAIT) begin
      PCWrite_o   = 1'b0;
      IFIDStall_o = 1'b1;
      NoOp_o      = 1'b1;
      is_stall    = 1'b1;
      lu_cnt_d    = lu_cnt_q - 4'd1;
      if (lu_cnt_q <= 4'd1) begin
        state_d = RUN;
      end
    end else if (lu_hit) begin
      PCWrite_o   = 1'b0;
      IFIDStall_o = 1'b1;
      NoOp_o      = 1'b1;
      is_stall    = 1'b1;
      if (LU_STALL > 1) begin
        state_d  = LU_WAIT;
        lu_cnt_d = LU_INIT;
      end
    end else if (br_tk) begin
      IFIDFlush_o = 1'b1;
      is_flush    = 1'b1;
    end
  end

  // State and bubble down-counter; reset aborts any pending bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      lu_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Saturating event counters; a clear request overrides any increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (is_stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (is_flush && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if (is_freeze && (freeze_cnt_q != CNT_MAX)) begin
        freeze_cnt_q <= freeze_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign freeze_cnt_o = freeze_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_hazard_ctrl_mc                                          |
// | Brief   : Self-checking bench for hazard_ctrl_mc. Three instances    |
// |           (LU_STALL 2/3/1) share one directed stimulus stream.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl_mc;

  localparam int N = 3;
  localparam int LS [N] = '{2, 3, 1};
  localparam int CW [N] = '{4, 16, 16};

  // control vector order: {PCWrite, IFIDStall, IFIDFlush, NoOp, Freeze}
  localparam logic [4:0] C_RST = 5'b00000;
  localparam logic [4:0] C_RUN = 5'b10000;
  localparam logic [4:0] C_STL = 5'b01010;
  localparam logic [4:0] C_FLS = 5'b10100;
  localparam logic [4:0] C_FRZ = 5'b01001;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       MemRead_IDEX_i = 1'b0;
  logic [4:0] rd_IDEX_i = '0, rs1_IFID_i = '0, rs2_IFID_i = '0;
  logic       rs1_used_i = 1'b0, rs2_used_i = 1'b0;
  logic       ID_equal_i = 1'b0, isBranch_i = 1'b0;
  logic       mem_stall_i = 1'b0, clr_cnt_i = 1'b0;

  logic [4:0]  ctl [N];
  logic [3:0]  sa, fa, za;
  logic [15:0] sb, fb, zb, sc, fc, zc;
  int          dut_s [N], dut_f [N], dut_z [N];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl_mc #(.RA_W(5), .LU_STALL(2), .CNT_W(4)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_IDEX_i(MemRead_IDEX_i), .rd_IDEX_i(rd_IDEX_i),
    .rs1_IFID_i(rs1_IFID_i), .rs2_IFID_i(rs2_IFID_i), .rs1_used_i(rs1_used_i),
    .rs2_used_i(rs2_used_i), .ID_equal_i(ID_equal_i), .isBranch_i(isBranch_i),
    .mem_stall_i(mem_stall_i), .clr_cnt_i(clr_cnt_i), .PCWrite_o(ctl[0][4]),
    .IFIDStall_o(ctl[0][3]), .IFIDFlush_o(ctl[0][2]), .NoOp_o(ctl[0][1]), .Freeze_o(ctl[0][0]),
    .stall_cnt_o(sa), .flush_cnt_o(fa), .freeze_cnt_o(za));

  hazard_ctrl_mc #(.RA_W(5), .LU_STALL(3), .CNT_W(16)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_IDEX_i(MemRead_IDEX_i), .rd_IDEX_i(rd_IDEX_i),
    .rs1_IFID_i(rs1_IFID_i), .rs2_IFID_i(rs2_IFID_i), .rs1_used_i(rs1_used_i),
    .rs2_used_i(rs2_used_i), .ID_equal_i(ID_equal_i), .isBranch_i(isBranch_i),
    .mem_stall_i(mem_stall_i), .clr_cnt_i(clr_cnt_i), .PCWrite_o(ctl[1][4]),
    .IFIDStall_o(ctl[1][3]), .IFIDFlush_o(ctl[1][2]), .NoOp_o(ctl[1][1]), .Freeze_o(ctl[1][0]),
    .stall_cnt_o(sb), .flush_cnt_o(fb), .freeze_cnt_o(zb));

  hazard_ctrl_mc #(.RA_W(5), .LU_STALL(1), .CNT_W(16)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_IDEX_i(MemRead_IDEX_i), .rd_IDEX_i(rd_IDEX_i),
    .rs1_IFID_i(rs1_IFID_i), .rs2_IFID_i(rs2_IFID_i), .rs1_used_i(rs1_used_i),
    .rs2_used_i(rs2_used_i), .ID_equal_i(ID_equal_i), .isBranch_i(isBranch_i),
    .mem_stall_i(mem_stall_i), .clr_cnt_i(clr_cnt_i), .PCWrite_o(ctl[2][4]),
    .IFIDStall_o(ctl[2][3]), .IFIDFlush_o(ctl[2][2]), .NoOp_o(ctl[2][1]), .Freeze_o(ctl[2][0]),
    .stall_cnt_o(sc), .flush_cnt_o(fc), .freeze_cnt_o(zc));

  always_comb begin
    dut_s[0] = int'(sa); dut_f[0] = int'(fa); dut_z[0] = int'(za);
    dut_s[1] = int'(sb); dut_f[1] = int'(fb); dut_z[1] = int'(zb);
    dut_s[2] = int'(sc); dut_f[2] = int'(fc); dut_z[2] = int'(zc);
  end

  // ---------------- behavioural model ----------------
  // rem = forced bubble cycles still owed after the current edge.
  int m_rem [N];
  int m_s [N], m_f [N], m_z [N];

  function automatic bit f_hit();
    return MemRead_IDEX_i && (rd_IDEX_i != 0) &&
           ((rs1_used_i && rd_IDEX_i == rs1_IFID_i) || (rs2_used_i && rd_IDEX_i == rs2_IFID_i));
  endfunction

  // 0 run, 1 flush, 2 stall, 3 freeze, 4 reset
  function automatic int f_kind(int k);
    if (!rst_i) return 4;
    if (mem_stall_i) return 3;
    if (m_rem[k] > 0 || f_hit()) return 2;
    if (ID_equal_i && isBranch_i) return 1;
    return 0;
  endfunction

  function automatic logic [4:0] f_ctl(int k);
    case (f_kind(k))
      4: return C_RST;
      3: return C_FRZ;
      2: return C_STL;
      1: return C_FLS;
      default: return C_RUN;
    endcase
  endfunction

  function automatic int f_sat(int v, int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_i) begin
        m_rem[k] <= 0; m_s[k] <= 0; m_f[k] <= 0; m_z[k] <= 0;
      end else begin
        case (f_kind(k))
          3: m_z[k] <= f_sat(m_z[k], CW[k]);
          2: begin
            m_s[k]   <= f_sat(m_s[k], CW[k]);
            m_rem[k] <= (m_rem[k] > 0) ? m_rem[k] - 1 : LS[k] - 1;
          end
          1: m_f[k] <= f_sat(m_f[k], CW[k]);
          default: ;
        endcase
        if (clr_cnt_i) begin
          m_s[k] <= 0; m_f[k] <= 0; m_z[k] <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      check("ctl", k, int'(ctl[k]), int'(f_ctl(k)));
      check("stall_cnt", k, dut_s[k], m_s[k]);
      check("flush_cnt", k, dut_f[k], m_f[k]);
      check("freeze_cnt", k, dut_z[k], m_z[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit mr, input int rd, input int r1, input int r2,
                        input bit u1, input bit u2, input bit br, input bit ms, input bit clr);
    MemRead_IDEX_i = mr;
    rd_IDEX_i  = 5'(rd);
    rs1_IFID_i = 5'(r1);
    rs2_IFID_i = 5'(r2);
    rs1_used_i = u1;
    rs2_used_i = u2;
    ID_equal_i = br;
    isBranch_i = br;
    mem_stall_i = ms;
    clr_cnt_i  = clr;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset
    #2;
    check("rst_ctl", 0, int'(ctl[0]), int'(C_RST));
    step(); step();
    rst_i = 1'b1;
    #1;
    check("post_rst_ctl", 0, int'(ctl[0]), int'(C_RUN));
    check("post_rst_stall", 0, dut_s[0], 0);
    idle(1);

    // 1: two-cycle load-use bubble
    clear();
    set_in(1, 5, 5, 0, 1, 0, 0, 0, 0); #1;
    check("lu_c1", 0, int'(ctl[0]), int'(C_STL));
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("lu_c2", 0, int'(ctl[0]), int'(C_STL));
    step(); #1;
    check("lu_done", 0, int'(ctl[0]), int'(C_RUN));
    check("lu_b_c3", 1, int'(ctl[1]), int'(C_STL));
    step();
    check("lu_scnt", 0, dut_s[0], 2);
    check("lu_scnt", 1, dut_s[1], 3);
    check("lu_scnt", 2, dut_s[2], 1);

    // 2: no false stall on x0 or unused rs2
    clear();
    set_in(1, 0, 0, 0, 1, 0, 0, 0, 0); #1;
    check("x0", 0, int'(ctl[0]), int'(C_RUN));
    step();
    set_in(1, 7, 3, 7, 1, 0, 0, 0, 0); #1;
    check("rs2_unused", 0, int'(ctl[0]), int'(C_RUN));
    step();
    idle(1);
    check("nostall_cnt", 0, dut_s[0], 0);

    // 3: stall beats flush, flush resumes once RUN
    clear();
    set_in(1, 5, 0, 5, 0, 1, 1, 0, 0); #1;
    check("stall_vs_br", 0, int'(ctl[0]), int'(C_STL));
    step();
    idle(3);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
    check("flush", 0, int'(ctl[0]), int'(C_FLS));
    step();
    check("flush_cnt", 0, dut_f[0], 1);
    check("flush_cnt", 1, dut_f[1], 1);
    idle(1);

    // 4: freeze in LU_WAIT holds the bubble count
    clear();
    set_in(1, 9, 9, 0, 1, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1; check("freeze", 1, int'(ctl[1]), int'(C_FRZ));
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1; check("post_frz_stall", 1, int'(ctl[1]), int'(C_STL));
      step();
    end
    #1;
    check("post_frz_run", 1, int'(ctl[1]), int'(C_RUN));
    check("frz_cnt", 1, dut_z[1], 4);
    check("frz_scnt", 1, dut_s[1], 3);
    idle(1);

    // 5: flush counter saturation and clear priority
    clear();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step();
    check("flush_sat", 0, dut_f[0], 15);
    check("flush_nosat", 1, dut_f[1], 20);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step();
    check("clr_wins", 0, dut_f[0], 0);
    check("clr_wins", 1, dut_f[1], 0);
    idle(1);

    // 6: asynchronous reset mid-LU_WAIT
    clear();
    set_in(1, 4, 4, 0, 1, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst_wait", 0, int'(ctl[0]), int'(C_STL));
    rst_i = 1'b0;
    #1;
    check("async_rst_ctl", 0, int'(ctl[0]), int'(C_RST));
    check("async_rst_scnt", 0, dut_s[0], 0);
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check("rel_ctl", 0, int'(ctl[0]), int'(C_RUN));
    check("rel_ctl", 1, int'(ctl[1]), int'(C_RUN));
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
